// File: rtl/instr_fetch_queue_if.sv
// Fetch queue bundle: instruction memory port, IF/ID head and control.
// master = fetch queue side, slave = pipeline / memory side.
interface instr_fetch_queue_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             stall;
    logic             flush;
    logic [PC_W-1:0]  redirect_pc;
    logic             imem_en;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata;
    logic             if_valid;
    logic [PC_W-1:0]  if_pc;
    logic [INS_W-1:0] if_instr;
    logic [CW-1:0]    occupancy;

    modport master (
        input  stall, flush, redirect_pc, imem_rdata,
        output imem_en, imem_addr, if_valid, if_pc, if_instr, occupancy
    );

    modport slave (
        output stall, flush, redirect_pc, imem_rdata,
        input  imem_en, imem_addr, if_valid, if_pc, if_instr, occupancy
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: sequential fetch, {pc,instr} FIFO,
// stall absorption without refetch, flush/redirect to a new PC.
module instr_fetch_queue #(
    parameter int PC_W     = 9,
    parameter int INS_W    = 32,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]  fpc_q, fpc_d;
    logic [PC_W-1:0]  req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [INS_W-1:0] ins_mem [DEPTH];

    logic             kill;
    logic             head;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CW:0]      need;

    assign kill  = reset | bus.flush;
    assign head  = ~reset & (cnt_q != '0);
    assign pop   = head & ~bus.stall & ~bus.flush;
    assign push  = inflight_q & ~kill;
    assign need  = {1'b0, cnt_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue = ~kill & (need < (CW+1)'(DEPTH));

    assign bus.imem_en   = issue;
    assign bus.imem_addr = fpc_q;
    assign bus.if_valid  = head;
    assign bus.if_pc     = head ? pc_mem[rd_q] : '0;
    assign bus.if_instr  = head ? ins_mem[rd_q] : '0;
    assign bus.occupancy = reset ? '0 : cnt_q;

    // Next-state: flush clears the queue and retargets fetch, else push/pop/issue.
    always_comb begin
        fpc_d      = fpc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        rd_d       = rd_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        if (bus.flush) begin
            fpc_d = bus.redirect_pc;
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            if (pop)
                rd_d = rd_q + AW'(1);
            if (push)
                wr_d = wr_q + AW'(1);
            if (issue) begin
                req_pc_d   = fpc_q;
                fpc_d      = fpc_q + PC_W'(4);
                inflight_d = 1'b1;
            end
        end
    end

    // Control registers; reset acts as a flush to RESET_PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q      <= PC_W'(RESET_PC);
            req_pc_q   <= PC_W'(RESET_PC);
            inflight_q <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            fpc_q      <= fpc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
        end
    end

    // FIFO storage: capture the returning instruction with its PC.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]  <= req_pc_q;
            ins_mem[wr_q] <= bus.imem_rdata;
        end
    end
endmodule
